// File: rtl/stage_if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package stage_if_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } if_state_e;

  // sll $0,$0,0
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register: hold beats flush, flush beats load.
module if_id_latch #(
  parameter logic [31:0] NOP_WORD = stage_if_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (reset || (!hold_i && flush_i)) begin
      pc_q    <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else if (!hold_i && load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/stage_if.sv
// Instruction fetch stage: PC, memory handshake FSM and branch/jump redirect.
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = stage_if_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_WORD = stage_if_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        inStall,
  input  logic        PCSrc,
  input  logic        Jump,
  input  logic [31:0] inAddBranch,
  input  logic [25:0] inJumpTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] outPcLatch,
  output logic [31:0] outInstruction,
  output logic        outValid
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] saved_q, saved_d;

  logic        advance, redirect;
  logic [31:0] target, pc_plus4;
  logic        lat_load, lat_flush, lat_hold;
  logic [31:0] lat_instr;

  assign advance  = enable & ~inStall;
  assign redirect = (PCSrc | Jump) & advance;
  assign target   = PCSrc ? inAddBranch : {outPcLatch[31:28], inJumpTarget, 2'b00};
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      saved_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      saved_q <= saved_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    saved_d   = saved_q;
    lat_load  = 1'b0;
    lat_flush = 1'b0;
    lat_hold  = ~advance;
    lat_instr = imemData;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          lat_flush = 1'b1;
          if (imemAck) begin
            pc_d = target;
          end else begin
            // Outstanding fetch must drain before the new PC can be issued.
            saved_d = target;
            state_d = DISCARD;
          end
        end else if (imemAck) begin
          if (advance) begin
            lat_load = 1'b1;
            pc_d     = pc_plus4;
          end else begin
            buf_d   = imemData;
            state_d = HOLD;
          end
        end else if (advance) begin
          lat_flush = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          lat_flush = 1'b1;
          pc_d      = target;
          state_d   = FETCH;
        end else if (advance) begin
          lat_load  = 1'b1;
          lat_instr = buf_q;
          pc_d      = pc_plus4;
          state_d   = FETCH;
        end
      end
      DISCARD: begin
        lat_hold = 1'b1;
        if (imemAck) begin
          pc_d    = saved_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign imemReq  = ~reset & (state_q != HOLD);
  assign imemAddr = pc_q;

  if_id_latch #(.NOP_WORD(NOP_WORD)) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load_i  (lat_load),
    .flush_i (lat_flush),
    .hold_i  (lat_hold),
    .pc_i    (pc_plus4),
    .instr_i (lat_instr),
    .pc_o    (outPcLatch),
    .instr_o (outInstruction),
    .valid_o (outValid)
  );

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: per-cycle vector table with a delivery scoreboard, plus a wrap/reset sequence.
module tb_stage_if;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, inStall, PCSrc, Jump, imemAck;
  logic [31:0] inAddBranch, imemData;
  logic [25:0] inJumpTarget;
  logic        imemReq, outValid;
  logic [31:0] imemAddr, outPcLatch, outInstruction;

  logic        w_reset, w_enable, w_inStall, w_PCSrc, w_Jump, w_imemAck;
  logic [31:0] w_inAddBranch, w_imemData;
  logic [25:0] w_inJumpTarget;
  logic        w_imemReq, w_outValid;
  logic [31:0] w_imemAddr, w_outPcLatch, w_outInstruction;

  stage_if u_dut (
    .clk(clk), .reset(reset), .enable(enable), .inStall(inStall),
    .PCSrc(PCSrc), .Jump(Jump), .inAddBranch(inAddBranch), .inJumpTarget(inJumpTarget),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .outPcLatch(outPcLatch), .outInstruction(outInstruction), .outValid(outValid)
  );

  stage_if #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(w_reset), .enable(w_enable), .inStall(w_inStall),
    .PCSrc(w_PCSrc), .Jump(w_Jump), .inAddBranch(w_inAddBranch), .inJumpTarget(w_inJumpTarget),
    .imemReq(w_imemReq), .imemAddr(w_imemAddr), .imemAck(w_imemAck), .imemData(w_imemData),
    .outPcLatch(w_outPcLatch), .outInstruction(w_outInstruction), .outValid(w_outValid)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        en, st, pcs, jmp;
    logic [31:0] br;
    logic [25:0] jt;
    logic        ack;
    logic [31:0] data;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        push;
    logic [31:0] p_pc;
  } vec_t;

  function automatic vec_t mk(logic en, logic st, logic pcs, logic jmp, logic [31:0] br,
                              logic [25:0] jt, logic ack, logic [31:0] data, logic e_req,
                              logic [31:0] e_addr, logic e_valid, logic push, logic [31:0] p_pc);
    vec_t v;
    v.en = en; v.st = st; v.pcs = pcs; v.jmp = jmp; v.br = br; v.jt = jt;
    v.ack = ack; v.data = data; v.e_req = e_req; v.e_addr = e_addr;
    v.e_valid = e_valid; v.push = push; v.p_pc = p_pc;
    return v;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  logic prev_adv;

  // A new IF/ID value is visible only after a cycle in which the stage advanced.
  task automatic monitor();
    exp_t e;
    if (!prev_adv) return;
    if (outValid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_word", outInstruction, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", outPcLatch, e.pc);
        chk("sb_instr", outInstruction, e.instr);
      end
    end else begin
      chk("bubble_instr", outInstruction, 32'h0000_0000);
      chk("bubble_pc", outPcLatch, 32'h0000_0000);
    end
  endtask

  vec_t vt[23];

  initial begin
    vt[0]  = mk(1,0,0,0,0,0,1,32'h1000_0001, 1,32'h0,1'b0, 1,32'd4);
    vt[1]  = mk(1,0,0,0,0,0,1,32'h1000_0002, 1,32'h4,1'b1, 1,32'd8);
    vt[2]  = mk(1,0,0,0,0,0,1,32'h1000_0003, 1,32'h8,1'b1, 1,32'd12);
    vt[3]  = mk(1,0,0,0,0,0,0,32'h0,         1,32'hC,1'b1, 0,32'd0);
    vt[4]  = mk(1,0,0,0,0,0,0,32'h0,         1,32'hC,1'b0, 0,32'd0);
    vt[5]  = mk(1,0,0,0,0,0,0,32'h0,         1,32'hC,1'b0, 0,32'd0);
    vt[6]  = mk(1,0,0,0,0,0,1,32'h1000_0004, 1,32'hC,1'b0, 1,32'd16);
    vt[7]  = mk(1,1,0,0,0,0,1,32'h1000_0005, 1,32'h10,1'b1, 0,32'd0);
    vt[8]  = mk(1,1,0,0,0,0,0,32'h0,         0,32'h10,1'b1, 0,32'd0);
    vt[9]  = mk(1,0,0,0,0,0,0,32'h1000_0005, 0,32'h10,1'b1, 1,32'd20);
    vt[10] = mk(1,0,1,0,32'h40,0,1,32'h1000_0006, 1,32'h14,1'b1, 0,32'd0);
    vt[11] = mk(1,0,0,0,0,0,1,32'h1000_0007, 1,32'h40,1'b0, 1,32'h44);
    vt[12] = mk(1,0,1,0,32'h1000_0004,0,1,32'hBAD0_0001, 1,32'h44,1'b1, 0,32'd0);
    vt[13] = mk(1,0,0,0,0,0,1,32'h1000_0008, 1,32'h1000_0004,1'b0, 1,32'h1000_0008);
    vt[14] = mk(1,0,0,1,0,26'h10,1,32'hBAD0_0002, 1,32'h1000_0008,1'b1, 0,32'd0);
    vt[15] = mk(1,0,1,0,32'h80,0,0,32'h0, 1,32'h1000_0040,1'b0, 0,32'd0);
    vt[16] = mk(1,0,1,0,32'h200,0,0,32'h0, 1,32'h1000_0040,1'b0, 0,32'd0);
    vt[17] = mk(1,0,0,0,0,0,1,32'hDEAD_BEEF, 1,32'h1000_0040,1'b0, 0,32'd0);
    vt[18] = mk(1,0,0,0,0,0,1,32'h1000_0009, 1,32'h80,1'b0, 1,32'h84);
    vt[19] = mk(1,0,0,0,0,0,0,32'h0,         1,32'h84,1'b1, 0,32'd0);
    vt[20] = mk(0,0,0,0,0,0,1,32'h1000_000A, 1,32'h84,1'b0, 0,32'd0);
    vt[21] = mk(1,0,0,0,0,0,0,32'h1000_000A, 0,32'h84,1'b0, 1,32'h88);
    vt[22] = mk(1,0,0,0,0,0,0,32'h0,         1,32'h88,1'b1, 0,32'd0);

    reset = 1'b1; enable = 1'b1; inStall = 1'b0; PCSrc = 1'b0; Jump = 1'b0;
    inAddBranch = '0; inJumpTarget = '0; imemAck = 1'b0; imemData = '0;
    w_reset = 1'b1; w_enable = 1'b1; w_inStall = 1'b0; w_PCSrc = 1'b0; w_Jump = 1'b0;
    w_inAddBranch = '0; w_inJumpTarget = '0; w_imemAck = 1'b0; w_imemData = '0;
    prev_adv = 1'b0;

    // Reset held with a pending ack that must be ignored.
    imemAck = 1'b1; imemData = 32'h5555_5555;
    step(); step();
    chk("rst_req", {31'd0, imemReq}, 32'd0);
    chk("rst_addr", imemAddr, 32'h0);
    chk("rst_instr", outInstruction, 32'h0000_0000);
    chk("rst_pc", outPcLatch, 32'h0);
    chk("rst_valid", {31'd0, outValid}, 32'd0);
    reset = 1'b0; imemAck = 1'b0;
    #1;

    for (int unsigned i = 0; i < 23; i++) begin
      chk($sformatf("v%0d_req", i), {31'd0, imemReq}, {31'd0, vt[i].e_req});
      chk($sformatf("v%0d_addr", i), imemAddr, vt[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'd0, outValid}, {31'd0, vt[i].e_valid});
      monitor();
      enable = vt[i].en; inStall = vt[i].st; PCSrc = vt[i].pcs; Jump = vt[i].jmp;
      inAddBranch = vt[i].br; inJumpTarget = vt[i].jt;
      imemAck = vt[i].ack; imemData = vt[i].data;
      if (vt[i].push) sb.push_back('{pc: vt[i].p_pc, instr: vt[i].data});
      prev_adv = vt[i].en & ~vt[i].st;
      step();
    end
    monitor();
    chk("sb_drained", sb.size(), 32'd0);

    // Wrap-around PC instance.
    step();
    chk("w_rst_req", {31'd0, w_imemReq}, 32'd0);
    chk("w_rst_addr", w_imemAddr, 32'hFFFF_FFFC);
    w_reset = 1'b0;
    #1;
    chk("w_first_req", {31'd0, w_imemReq}, 32'd1);
    chk("w_first_addr", w_imemAddr, 32'hFFFF_FFFC);
    w_imemAck = 1'b1; w_imemData = 32'h0000_1234;
    step();
    chk("w_pclatch", w_outPcLatch, 32'h0);
    chk("w_instr", w_outInstruction, 32'h0000_1234);
    chk("w_valid", {31'd0, w_outValid}, 32'd1);
    chk("w_next_addr", w_imemAddr, 32'h0);
    w_imemAck = 1'b0;
    step();
    chk("w_wait_addr", w_imemAddr, 32'h0);
    w_reset = 1'b1;
    step();
    chk("w_midrst_req", {31'd0, w_imemReq}, 32'd0);
    chk("w_midrst_valid", {31'd0, w_outValid}, 32'd0);
    w_reset = 1'b0;
    #1;
    chk("w_post_req", {31'd0, w_imemReq}, 32'd1);
    chk("w_post_addr", w_imemAddr, 32'hFFFF_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_if.md
STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, instruction word injected on flush/reset (sll $0,$0,0).
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  global pipeline enable; 0 freezes the stage.
REQ-006 inStall  input  1  hazard stall from ID; 0 lets the stage advance.
REQ-007 PCSrc  input  1  taken branch resolved in ID.
REQ-008 Jump  input  1  jump decoded in ID.
REQ-009 inAddBranch  input  32  branch target from the ID adder.
REQ-010 inJumpTarget  input  26  instr_index field of the jump in ID.
REQ-011 imemReq  output  1  instruction-memory request.
REQ-012 imemAddr  output  32  fetch byte address; equals the PC.
REQ-013 imemAck  input  1  memory data valid; ignored while imemReq=0.
REQ-014 imemData  input  32  instruction word, valid with imemAck.
REQ-015 outPcLatch  output  32  IF/ID PC+4 of the latched instruction.
REQ-016 outInstruction  output  32  IF/ID instruction word; ID slices opCode/rs/rt/rd/sa/function/immediate from it.
REQ-017 outValid  output  1  IF/ID holds a real instruction (0 = bubble).

Function
REQ-018 FSM states FETCH, HOLD, DISCARD shall exist; FETCH is entered after reset.
REQ-019 FETCH: imemReq=1, imemAddr=PC, held stable until imemAck; zero-wait ack (same cycle as request) is legal.
REQ-020 FETCH, imemAck=1, advance (enable=1, inStall=0), no redirect: IF/ID <= {PC+4, imemData, valid=1}; PC <= PC+4; stay FETCH.
REQ-021 FETCH, imemAck=1, not advancing: word stored in an internal buffer; go HOLD; imemReq=0 in HOLD.
REQ-022 HOLD, advance, no redirect: IF/ID <= buffered word; PC <= PC+4; go FETCH.
REQ-023 Redirect = (PCSrc|Jump) while enable=1 and inStall=0; redirect is ignored while stalled or disabled (ID re-asserts it).
REQ-024 Redirect target: PCSrc has priority -> inAddBranch; else Jump -> {outPcLatch[31:28], inJumpTarget, 2'b00}.
REQ-025 Redirect in FETCH with imemAck=1 or in HOLD: fetched/buffered word dropped; IF/ID <= {0, NOP_WORD, valid=0}; PC <= target; go FETCH.
REQ-026 Redirect in FETCH with imemAck=0: target saved; IF/ID flushed to bubble; go DISCARD; request stays asserted on the old address.
REQ-027 DISCARD: on imemAck, data dropped, PC <= saved target, go FETCH; IF/ID keeps bubble; later redirects are ignored until return to FETCH.
REQ-028 FETCH with imemAck=0 and no redirect: IF/ID <= bubble if advancing, else unchanged.
REQ-029 Stall or enable=0 shall leave IF/ID and PC unchanged in every state.
REQ-030 PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
REQ-031 Latency: imemAck-to-outInstruction is one clock when not stalled.

Reset
REQ-032 While reset=1: PC=RESET_PC, state=FETCH, imemReq=0, outInstruction=NOP_WORD, outPcLatch=0, outValid=0, buffer and saved target cleared.
REQ-033 Reset mid-handshake abandons the request; the first post-reset cycle requests RESET_PC.

Structure
REQ-034 Package stage_if_pkg holds the FSM state enum, NOP_WORD and default RESET_PC.
REQ-035 IF/ID register is one sub-module, if_id_latch (load, flush, hold inputs).

Verification
REQ-036 Reset, zero-wait memory returning words 0x1000_0001..: outInstruction follows one clock behind, outPcLatch 4, 8, 12.
REQ-037 Ack after 3 wait cycles: imemAddr stable; outValid=0 for 3 cycles, then word with outPcLatch=PC+4.
REQ-038 inStall=1 for 2 cycles at ack: HOLD entered, imemReq=0, IF/ID frozen; release delivers buffered word, PC+4.
REQ-039 PCSrc=1, inAddBranch=0x40 with ack: next outValid=0, imemAddr=0x40; Jump with outPcLatch=0x1000_0008, index 0x10 -> 0x1000_0040.
REQ-040 Redirect to 0x80 while ack pending 2 cycles: DISCARD entered, late word never appears, next request is 0x80.
REQ-041 RESET_PC=0xFFFF_FFFC: first outPcLatch=0, next imemAddr=0; reset mid-wait -> imemAddr=RESET_PC.
